// File: rtl/alu_issue_stage.sv
// Two-stage issue/retire wrapper around the combinational ALU: decodes MIPS R/I-type
// ALU instructions onto registered ALU inputs, then captures and classifies the result.
module alu_issue_stage #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  instr,
    input  logic [n-1:0] rs_data,
    input  logic [n-1:0] rt_data,
    input  logic         flush,
    output logic [n-1:0] alu_a,
    output logic [n-1:0] alu_b,
    output logic [3:0]   alu_af,
    output logic         alu_i,
    input  logic [n-1:0] alu_res,
    input  logic         alu_ovf,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] out_res,
    output logic [4:0]   out_dest,
    output logic         out_we,
    output logic         out_ovf_exc,
    output logic         out_illegal
);

    logic [5:0]   opcode, funct;
    logic [15:0]  imm;
    logic [n-1:0] imm_sext, imm_zext;

    logic [3:0]   dec_af;
    logic         dec_i, dec_illegal, dec_trap;
    logic [n-1:0] dec_b;
    logic [4:0]   dec_dest;

    logic         s1_valid_q, s1_valid_d;
    logic [n-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]   alu_af_q, alu_af_d;
    logic         alu_i_q, alu_i_d;
    logic [4:0]   s1_dest_q, s1_dest_d;
    logic         s1_illegal_q, s1_illegal_d;
    logic         s1_trap_q, s1_trap_d;

    logic         out_valid_q, out_valid_d;
    logic [n-1:0] out_res_q, out_res_d;
    logic [4:0]   out_dest_q, out_dest_d;
    logic         out_ovf_exc_q, out_ovf_exc_d;
    logic         out_illegal_q, out_illegal_d;

    logic         s1_load, s2_load;
    logic         unused_instr_fields;

    assign opcode   = instr[31:26];
    assign funct    = instr[5:0];
    assign imm      = instr[15:0];
    assign imm_sext = {{(n-16){imm[15]}}, imm};
    assign imm_zext = {{(n-16){1'b0}}, imm};

    // rs/shamt fields are resolved upstream (rs_data) or not supported (shifts)
    assign unused_instr_fields = ^{instr[25:21], instr[10:6]};

    always_comb begin
        dec_af      = 4'b0000;
        dec_i       = 1'b0;
        dec_b       = rt_data;
        dec_dest    = instr[15:11];
        dec_illegal = 1'b0;
        dec_trap    = 1'b0;
        if (opcode == 6'b000000) begin
            case (funct)
                6'b100000: begin dec_af = 4'b0000; dec_trap = 1'b1; end
                6'b100001: dec_af = 4'b0001;
                6'b100010: begin dec_af = 4'b0010; dec_trap = 1'b1; end
                6'b100011: dec_af = 4'b0011;
                6'b100100: dec_af = 4'b0100;
                6'b100101: dec_af = 4'b0101;
                6'b100110: dec_af = 4'b0110;
                6'b100111: dec_af = 4'b0111;
                6'b101010: dec_af = 4'b1010;
                6'b101011: dec_af = 4'b1011;
                default:   dec_illegal = 1'b1;
            endcase
        end else begin
            dec_dest = instr[20:16];
            case (opcode)
                6'b001000: begin dec_i = 1'b1; dec_af = 4'b0000; dec_b = imm_sext; dec_trap = 1'b1; end
                6'b001001: begin dec_i = 1'b1; dec_af = 4'b0001; dec_b = imm_sext; end
                6'b001010: begin dec_i = 1'b1; dec_af = 4'b1010; dec_b = imm_sext; end
                6'b001011: begin dec_i = 1'b1; dec_af = 4'b1011; dec_b = imm_sext; end
                6'b001100: begin dec_i = 1'b1; dec_af = 4'b0100; dec_b = imm_zext; end
                6'b001101: begin dec_i = 1'b1; dec_af = 4'b0101; dec_b = imm_zext; end
                6'b001110: begin dec_i = 1'b1; dec_af = 4'b0110; dec_b = imm_zext; end
                // lui: ALU shifts b left by 16 itself
                6'b001111: begin dec_i = 1'b1; dec_af = 4'b0111; dec_b = imm_zext; end
                default:   dec_illegal = 1'b1;
            endcase
        end
    end

    assign s2_load  = s1_valid_q & (~out_valid_q | out_ready);
    assign in_ready = ~s1_valid_q | s2_load;
    assign s1_load  = in_valid & in_ready & ~flush;

    always_comb begin
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_af_d      = alu_af_q;
        alu_i_d       = alu_i_q;
        s1_dest_d     = s1_dest_q;
        s1_illegal_d  = s1_illegal_q;
        s1_trap_d     = s1_trap_q;
        out_res_d     = out_res_q;
        out_dest_d    = out_dest_q;
        out_ovf_exc_d = out_ovf_exc_q;
        out_illegal_d = out_illegal_q;

        if (s1_load) begin
            alu_a_d      = rs_data;
            alu_b_d      = dec_b;
            alu_af_d     = dec_af;
            alu_i_d      = dec_i;
            s1_dest_d    = dec_dest;
            s1_illegal_d = dec_illegal;
            s1_trap_d    = dec_trap;
        end

        if (s2_load & ~flush) begin
            out_res_d     = alu_res;
            out_dest_d    = s1_dest_q;
            out_ovf_exc_d = s1_trap_q & alu_ovf;
            out_illegal_d = s1_illegal_q;
        end

        if (flush)        s1_valid_d = 1'b0;
        else if (s1_load) s1_valid_d = 1'b1;
        else if (s2_load) s1_valid_d = 1'b0;
        else              s1_valid_d = s1_valid_q;

        if (flush)          out_valid_d = 1'b0;
        else if (s2_load)   out_valid_d = 1'b1;
        else if (out_ready) out_valid_d = 1'b0;
        else                out_valid_d = out_valid_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q    <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_af_q      <= 4'b0000;
            alu_i_q       <= 1'b0;
            s1_dest_q     <= 5'd0;
            s1_illegal_q  <= 1'b0;
            s1_trap_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            out_res_q     <= '0;
            out_dest_q    <= 5'd0;
            out_ovf_exc_q <= 1'b0;
            out_illegal_q <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_af_q      <= alu_af_d;
            alu_i_q       <= alu_i_d;
            s1_dest_q     <= s1_dest_d;
            s1_illegal_q  <= s1_illegal_d;
            s1_trap_q     <= s1_trap_d;
            out_valid_q   <= out_valid_d;
            out_res_q     <= out_res_d;
            out_dest_q    <= out_dest_d;
            out_ovf_exc_q <= out_ovf_exc_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_af      = alu_af_q;
    assign alu_i       = alu_i_q;
    assign out_valid   = out_valid_q;
    assign out_res     = out_res_q;
    assign out_dest    = out_dest_q;
    assign out_ovf_exc = out_ovf_exc_q;
    assign out_illegal = out_illegal_q;
    assign out_we      = out_valid_q & ~out_ovf_exc_q & ~out_illegal_q & (out_dest_q != 5'd0);

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU on the alu_* ports, instruction-level
// reference model feeding an in-order scoreboard, directed steps then random traffic.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        flush = 1'b0;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_af;
    logic        alu_i;
    logic [31:0] alu_res;
    logic        alu_ovf;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_res;
    logic [4:0]  out_dest;
    logic        out_we, out_ovf_exc, out_illegal;

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.n(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
        .alu_a(alu_a), .alu_b(alu_b), .alu_af(alu_af), .alu_i(alu_i),
        .alu_res(alu_res), .alu_ovf(alu_ovf),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .out_dest(out_dest), .out_we(out_we), .out_ovf_exc(out_ovf_exc),
        .out_illegal(out_illegal)
    );

    // Environment: the combinational ALU the stage drives.
    logic [31:0] sum_t, dif_t;
    assign sum_t = alu_a + alu_b;
    assign dif_t = alu_a - alu_b;
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (alu_af)
            4'b0000, 4'b0001: begin
                alu_res = sum_t;
                alu_ovf = (alu_a[31] == alu_b[31]) && (sum_t[31] != alu_a[31]);
            end
            4'b0010, 4'b0011: begin
                alu_res = dif_t;
                alu_ovf = (alu_a[31] != alu_b[31]) && (dif_t[31] != alu_a[31]);
            end
            4'b0100: alu_res = alu_a & alu_b;
            4'b0101: alu_res = alu_a | alu_b;
            4'b0110: alu_res = alu_a ^ alu_b;
            4'b0111: alu_res = alu_i ? (alu_b << 16) : ~(alu_a | alu_b);
            4'b1010: alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'b1011: alu_res = {31'd0, alu_a < alu_b};
            default: alu_res = '0;
        endcase
    end

    typedef struct {
        logic [31:0] res;
        logic [4:0]  dest;
        logic        exc;
        logic        ill;
    } exp_t;

    exp_t q[$];

    function automatic exp_t ref_model(logic [31:0] ins, logic [31:0] rs, logic [31:0] rt);
        exp_t e;
        logic [31:0] se, ze;
        logic [32:0] w;
        se = {{16{ins[15]}}, ins[15:0]};
        ze = {16'd0, ins[15:0]};
        e.res = '0; e.exc = 1'b0; e.ill = 1'b0;
        e.dest = (ins[31:26] == 6'd0) ? ins[15:11] : ins[20:16];
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h20: begin w = {rs[31], rs} + {rt[31], rt}; e.res = w[31:0]; e.exc = w[32] ^ w[31]; end
                6'h21: e.res = rs + rt;
                6'h22: begin w = {rs[31], rs} - {rt[31], rt}; e.res = w[31:0]; e.exc = w[32] ^ w[31]; end
                6'h23: e.res = rs - rt;
                6'h24: e.res = rs & rt;
                6'h25: e.res = rs | rt;
                6'h26: e.res = rs ^ rt;
                6'h27: e.res = ~(rs | rt);
                6'h2a: e.res = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
                6'h2b: e.res = (rs < rt) ? 32'd1 : 32'd0;
                default: e.ill = 1'b1;
            endcase
            6'h08: begin w = {rs[31], rs} + {se[31], se}; e.res = w[31:0]; e.exc = w[32] ^ w[31]; end
            6'h09: e.res = rs + se;
            6'h0a: e.res = ($signed(rs) < $signed(se)) ? 32'd1 : 32'd0;
            6'h0b: e.res = (rs < se) ? 32'd1 : 32'd0;
            6'h0c: e.res = rs & ze;
            6'h0d: e.res = rs | ze;
            6'h0e: e.res = rs ^ ze;
            6'h0f: e.res = {ins[15:0], 16'd0};
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rtype(logic [5:0] fn, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (q.size() == 0) begin
            chk("unexpected_output", {31'd0, out_valid}, 32'd0);
        end else begin
            e = q.pop_front();
            if (!e.ill) begin
                chk("sb_res", out_res, e.res);
                chk("sb_dest", {27'd0, out_dest}, {27'd0, e.dest});
            end
            chk("sb_ovf_exc", {31'd0, out_ovf_exc}, {31'd0, e.exc});
            chk("sb_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
            chk("sb_we", {31'd0, out_we}, {31'd0, !e.exc && !e.ill && (e.dest != 5'd0)});
        end
    endtask

    // Called just after a falling edge with inputs set; returns at the next falling edge.
    task automatic tick(output bit acc);
        #1;
        acc = in_valid && in_ready && !flush && !reset;
        if (out_valid && out_ready && !flush) check_out();
        if (acc) q.push_back(ref_model(instr, rs_data, rt_data));
        if (flush) q.delete();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1; instr = ins; rs_data = a; rt_data = b;
        for (int k = 0; k < 50 && !acc; k++) tick(acc);
        chk("send_accepted", {31'd0, acc}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        out_ready = 1'b1;
        for (int k = 0; k < 50 && (q.size() > 0 || out_valid); k++) tick(acc);
        chk("drain_empty", q.size(), 32'd0);
        chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] fns [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
        logic [5:0] ops [8]  = '{6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f};
        int k;
        logic [4:0] r1, r2, r3;
        k  = $urandom_range(0, 18);
        r1 = 5'($urandom); r2 = 5'($urandom); r3 = 5'($urandom);
        if (k < 10) return rtype(fns[k], r1, r2, r3);
        if (k < 18) return itype(ops[k-10], r1, r2, 16'($urandom));
        return ($urandom_range(0, 1) == 0) ? itype(6'h23, r1, r2, 16'($urandom)) : rtype(6'h00, r1, r2, r3);
    endfunction

    function automatic logic [31:0] rand_data();
        case ($urandom_range(0, 4))
            0: return 32'h7fffffff;
            1: return 32'h80000000;
            2: return 32'hffffffff;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #20000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bit acc;
        int idx;
        logic [31:0] held_res, held_a;

        // reset state while reset is asserted
        #3;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_af", {28'd0, alu_af}, 32'd0);
        chk("rst_out_res", out_res, 32'd0);
        chk("rst_out_we", {31'd0, out_we}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // add $3,$1,$2 : latency and result
        out_ready = 1'b1;
        send(rtype(6'h20, 5'd1, 5'd2, 5'd3), 32'd5, 32'd7);
        chk("add_alu_af", {28'd0, alu_af}, 32'd0);
        chk("add_alu_i", {31'd0, alu_i}, 32'd0);
        chk("add_alu_a", alu_a, 32'd5);
        chk("add_alu_b", alu_b, 32'd7);
        chk("add_not_yet_valid", {31'd0, out_valid}, 32'd0);
        tick(acc);
        chk("add_out_valid", {31'd0, out_valid}, 32'd1);
        chk("add_out_res", out_res, 32'd12);
        chk("add_out_dest", {27'd0, out_dest}, 32'd3);
        chk("add_out_we", {31'd0, out_we}, 32'd1);
        drain();

        // addi overflow traps, addiu does not
        send(itype(6'h08, 5'd1, 5'd5, 16'h0001), 32'h7fffffff, 32'd0);
        tick(acc);
        chk("addi_exc", {31'd0, out_ovf_exc}, 32'd1);
        chk("addi_we", {31'd0, out_we}, 32'd0);
        drain();
        send(itype(6'h09, 5'd1, 5'd5, 16'h0001), 32'h7fffffff, 32'd0);
        tick(acc);
        chk("addiu_res", out_res, 32'h80000000);
        chk("addiu_exc", {31'd0, out_ovf_exc}, 32'd0);
        chk("addiu_we", {31'd0, out_we}, 32'd1);
        drain();

        // lui / ori / slti
        send(itype(6'h0f, 5'd0, 5'd4, 16'h1234), 32'hdeadbeef, 32'd0);
        tick(acc);
        chk("lui_res", out_res, 32'h12340000);
        drain();
        send(itype(6'h0d, 5'd4, 5'd4, 16'hffff), 32'h12340000, 32'd0);
        chk("ori_alu_b", alu_b, 32'h0000ffff);
        tick(acc);
        chk("ori_res", out_res, 32'h1234ffff);
        drain();
        send(itype(6'h0a, 5'd1, 5'd6, 16'hfffe), 32'hffffffff, 32'd0);
        tick(acc);
        chk("slti_res", out_res, 32'd0);
        drain();

        // four back-to-back addu with a three-cycle consumer stall
        idx = 0;
        for (int cyc = 0; cyc < 30 && (idx < 4 || q.size() > 0 || out_valid); cyc++) begin
            out_ready = !(cyc >= 3 && cyc < 6);
            in_valid  = (idx < 4);
            instr     = rtype(6'h21, 5'd1, 5'd2, 5'(idx + 8));
            rs_data   = 32'd1000 * (idx + 1);
            rt_data   = 32'd3 + idx;
            #1;
            if (cyc == 3) begin
                held_res = out_res;
                held_a   = alu_a;
            end
            if (cyc >= 3 && cyc < 6) begin
                chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_out_res", out_res, held_res);
                chk("stall_alu_a", alu_a, held_a);
            end
            tick(acc);
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk("stream_sent", idx, 32'd4);
        drain();

        // flush with both stages full and a new instruction offered
        out_ready = 1'b0;
        send(rtype(6'h21, 5'd1, 5'd2, 5'd9), 32'd11, 32'd22);
        send(rtype(6'h21, 5'd1, 5'd2, 5'd10), 32'd33, 32'd44);
        chk("pre_flush_out_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b1; instr = rtype(6'h21, 5'd1, 5'd2, 5'd11); flush = 1'b1;
        tick(acc);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(acc);
            chk("flush_nothing_emitted", {31'd0, out_valid}, 32'd0);
        end

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        send(rtype(6'h21, 5'd1, 5'd2, 5'd12), 32'h55, 32'h66);
        send(rtype(6'h25, 5'd1, 5'd2, 5'd13), 32'hf0, 32'h0f);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_alu_a", alu_a, 32'd0);
        chk("arst_alu_b", alu_b, 32'd0);
        chk("arst_out_res", out_res, 32'd0);
        chk("arst_out_dest", {27'd0, out_dest}, 32'd0);
        chk("arst_out_we", {31'd0, out_we}, 32'd0);
        q.delete();
        @(negedge clk);
        reset = 1'b0;

        // illegal opcodes and writes to $0
        out_ready = 1'b1;
        send({6'b000010, 26'h0000123}, 32'd1, 32'd2);
        tick(acc);
        chk("j_illegal", {31'd0, out_illegal}, 32'd1);
        chk("j_we", {31'd0, out_we}, 32'd0);
        drain();
        send(rtype(6'h00, 5'd1, 5'd2, 5'd5), 32'd1, 32'd2);
        tick(acc);
        chk("sll_illegal", {31'd0, out_illegal}, 32'd1);
        chk("sll_we", {31'd0, out_we}, 32'd0);
        drain();
        send(rtype(6'h20, 5'd1, 5'd2, 5'd0), 32'd1, 32'd2);
        tick(acc);
        chk("add_r0_we", {31'd0, out_we}, 32'd0);
        chk("add_r0_valid", {31'd0, out_valid}, 32'd1);
        drain();

        // random traffic against the scoreboard
        for (int cyc = 0; cyc < 400; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            instr     = rand_instr();
            rs_data   = rand_data();
            rt_data   = rand_data();
            tick(acc);
        end
        in_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
